// File: rtl/uart_tx_serializer.sv
// Byte-wide UART transmitter: start bit, LSB-first data, optional parity, stop bit(s).
// All outputs are registered; TransBusy spans accept through the last stop-bit cycle.
module uart_tx_serializer #(
  parameter int CLK_FREQ       = 100_000_000,
  parameter int BAUD_RATE      = 115_200,
  parameter int UART_BIT_WIDTH = 8,
  parameter int PARITY         = 0,
  parameter int STOP_BITS      = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      EnTrans,
  input  logic [UART_BIT_WIDTH-1:0] TransData,
  output logic                      TransBusy,
  output logic                      Tx,
  output logic                      Overrun
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int CNT_W        = (STOP_BITS * CLKS_PER_BIT > 1) ? $clog2(STOP_BITS * CLKS_PER_BIT) : 1;
  localparam int IDX_W        = (UART_BIT_WIDTH > 1) ? $clog2(UART_BIT_WIDTH) : 1;

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_BITS * CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(UART_BIT_WIDTH - 1);

  if (CLKS_PER_BIT < 2) begin : g_bad_cpb
    $error("uart_tx_serializer: CLKS_PER_BIT must be at least 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("uart_tx_serializer: STOP_BITS must be 1 or 2");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $error("uart_tx_serializer: PARITY must be 0, 1 or 2");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t                    state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [UART_BIT_WIDTH-1:0] shift_q, shift_d;
  logic                      par_q, par_d;
  logic                      tx_q, tx_d;
  logic                      busy_q, busy_d;
  logic                      ovr_q, ovr_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      ovr_q   <= ovr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    idx_d   = idx_q;
    shift_d = shift_q;
    par_d   = par_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    ovr_d   = EnTrans && (state_q != S_IDLE);

    unique case (state_q)
      S_IDLE: begin
        cnt_d  = '0;
        idx_d  = '0;
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (EnTrans) begin
          shift_d = TransData;
          par_d   = (PARITY == 1) ? ~^TransData : ^TransData;
          state_d = S_START;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
        end
      end

      S_START: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          state_d = S_DATA;
          tx_d    = shift_q[0];
        end
      end

      // The shift register always presents the current bit at [0]; the next
      // bit to drive on a wrap is therefore [1] of the pre-shift value.
      S_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (idx_q == IDX_LAST) begin
            if (PARITY != 0) begin
              state_d = S_PARITY;
              tx_d    = par_q;
            end else begin
              state_d = S_STOP;
              tx_d    = 1'b1;
            end
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
          end
        end
      end

      S_PARITY: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          state_d = S_STOP;
          tx_d    = 1'b1;
        end
      end

      S_STOP: begin
        tx_d = 1'b1;
        if (cnt_q == STOP_LAST) begin
          cnt_d   = '0;
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        idx_d   = '0;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign Tx        = tx_q;
  assign TransBusy = busy_q;
  assign Overrun   = ovr_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer: three instances (no/even/odd parity)
// at 10 clocks per bit, driven from a vector table plus reset/overrun sequences.
module tb_uart_tx_serializer;

  localparam int CF  = 1_000_000;
  localparam int BR  = 100_000;
  localparam int CPB = 10;

  logic       clk = 1'b0;
  logic       rst;
  logic       en     [3];
  logic [7:0] data   [3];
  logic       busy   [3];
  logic       tx     [3];
  logic       ovr    [3];

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  uart_tx_serializer #(.CLK_FREQ(CF), .BAUD_RATE(BR), .UART_BIT_WIDTH(8),
                       .PARITY(0), .STOP_BITS(1)) u_p0 (
    .clk(clk), .rst(rst), .EnTrans(en[0]), .TransData(data[0]),
    .TransBusy(busy[0]), .Tx(tx[0]), .Overrun(ovr[0]));

  uart_tx_serializer #(.CLK_FREQ(CF), .BAUD_RATE(BR), .UART_BIT_WIDTH(8),
                       .PARITY(2), .STOP_BITS(1)) u_even (
    .clk(clk), .rst(rst), .EnTrans(en[1]), .TransData(data[1]),
    .TransBusy(busy[1]), .Tx(tx[1]), .Overrun(ovr[1]));

  uart_tx_serializer #(.CLK_FREQ(CF), .BAUD_RATE(BR), .UART_BIT_WIDTH(8),
                       .PARITY(1), .STOP_BITS(1)) u_odd (
    .clk(clk), .rst(rst), .EnTrans(en[2]), .TransData(data[2]),
    .TransBusy(busy[2]), .Tx(tx[2]), .Overrun(ovr[2]));

  typedef struct {
    string       name;
    int          sel;   // 0 = no parity, 1 = even, 2 = odd
    logic [7:0]  d;
    logic [11:0] exp;   // expected line bits in time order, bit 0 = start bit
    int          nb;    // bits per frame
  } vec_t;

  vec_t vecs[9];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Called one sample point after an edge; drives the request immediately, so
  // back-to-back calls reproduce the one-idle-cycle handshake.
  task automatic run_frame(input int sel, input logic [7:0] d, input logic [11:0] exp,
                           input int nb, input int ovr_at, input string nm);
    int          cyc;
    int          b;
    int          ovr_extra;
    logic [11:0] got;
    logic [11:0] bad;
    cyc = 0; ovr_extra = 0; got = '0; bad = '0;
    check({nm, " idle-before"}, 32'({busy[sel], tx[sel]}), 32'b01);
    en[sel]   = 1'b1;
    data[sel] = d;
    tick();
    en[sel] = 1'b0;
    while (busy[sel] && cyc < 300) begin
      b = cyc / CPB;
      if (b < 12) begin
        if (cyc % CPB == CPB / 2) got[b] = tx[sel];
        if (tx[sel] !== exp[b]) bad[b] = 1'b1;
      end
      if (ovr_at >= 0 && cyc == ovr_at) begin
        en[sel]   = 1'b1;
        data[sel] = 8'h3C;
      end else if (ovr_at >= 0 && cyc == ovr_at + 1) begin
        en[sel] = 1'b0;
        check({nm, " overrun-pulse"}, 32'(ovr[sel]), 32'd1);
      end else if (ovr[sel] !== 1'b0) begin
        ovr_extra++;
      end
      cyc++;
      tick();
    end
    check({nm, " busy-cycles"}, 32'(cyc), 32'(nb * CPB));
    for (int i = 0; i < nb; i++)
      check($sformatf("%s bit%0d {glitch,mid}", nm, i), 32'({bad[i], got[i]}), 32'({1'b0, exp[i]}));
    check({nm, " stray-overrun"}, 32'(ovr_extra), 32'd0);
    check({nm, " idle-after"}, 32'({busy[sel], tx[sel]}), 32'b01);
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int viol;

    vecs[0] = '{"p0 A5",   0, 8'hA5, 12'({1'b1, 8'hA5, 1'b0}), 10};
    vecs[1] = '{"even A5", 1, 8'hA5, 12'({1'b1, 1'b0, 8'hA5, 1'b0}), 11};
    vecs[2] = '{"odd A5",  2, 8'hA5, 12'({1'b1, 1'b1, 8'hA5, 1'b0}), 11};
    vecs[3] = '{"even 07", 1, 8'h07, 12'({1'b1, 1'b1, 8'h07, 1'b0}), 11};
    vecs[4] = '{"b2b 55",  0, 8'h55, 12'({1'b1, 8'h55, 1'b0}), 10};
    vecs[5] = '{"b2b 00",  0, 8'h00, 12'({1'b1, 8'h00, 1'b0}), 10};
    vecs[6] = '{"b2b FF",  0, 8'hFF, 12'({1'b1, 8'hFF, 1'b0}), 10};
    vecs[7] = '{"b2b 01",  0, 8'h01, 12'({1'b1, 8'h01, 1'b0}), 10};
    vecs[8] = '{"b2b 80",  0, 8'h80, 12'({1'b1, 8'h80, 1'b0}), 10};

    for (int i = 0; i < 3; i++) begin
      en[i]   = 1'b0;
      data[i] = 8'h00;
    end
    rst = 1'b1;
    repeat (3) tick();
    for (int i = 0; i < 3; i++)
      check($sformatf("reset-state inst%0d {tx,busy,ovr}", i),
            32'({tx[i], busy[i], ovr[i]}), 32'b100);
    rst = 1'b0;

    viol = 0;
    for (int c = 0; c < 50; c++) begin
      tick();
      for (int i = 0; i < 3; i++)
        if ({tx[i], busy[i], ovr[i]} !== 3'b100) viol++;
    end
    check("quiet-50-cycles violations", 32'(viol), 32'd0);

    for (int v = 0; v < 9; v++)
      run_frame(vecs[v].sel, vecs[v].d, vecs[v].exp, vecs[v].nb, -1, vecs[v].name);

    tick();
    run_frame(0, 8'hA5, 12'({1'b1, 8'hA5, 1'b0}), 10, 40, "overrun A5");
    viol = 0;
    for (int c = 0; c < 30; c++) begin
      if ({busy[0], tx[0], ovr[0]} !== 3'b010) viol++;
      tick();
    end
    check("dropped 3C never sent", 32'(viol), 32'd0);

    en[0]   = 1'b1;
    data[0] = 8'h5A;
    tick();
    en[0] = 1'b0;
    repeat (35) tick();
    check("mid-frame data bit2 low", 32'({busy[0], tx[0]}), 32'b10);
    rst = 1'b1;
    #1;
    check("async abort {busy,tx,ovr}", 32'({busy[0], tx[0], ovr[0]}), 32'b010);
    tick();
    check("held reset {busy,tx}", 32'({busy[0], tx[0]}), 32'b01);
    tick();
    rst = 1'b0;
    tick();
    run_frame(0, 8'hC3, 12'({1'b1, 8'hC3, 1'b0}), 10, -1, "post-reset C3");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
